l2_cache_control: RTL and testbench

Sequencing FSM for the 4-way L2 cache datapath. It sits between the L1-side request port and physical memory. It drives the datapath's `new_data`, `we`, `wdata_sel` and `wb` controls from the datapath's `hit`/`dirty` status, so that hits, clean misses and dirty write-back-then-fill misses complete as whole-line transactions. One transaction is in flight at a time.

---
 rtl/l2_cache_control.sv | 170 +++++++++++++++++
 tb/tb_l2_cache_control.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/l2_cache_control.sv
// Sequencing FSM for the 4-way L2 cache datapath: hits, clean misses and dirty
// write-back-then-fill misses. Optional performance counters: L2_CACHE_PERF_COUNTERS_EN.
module l2_cache_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 dp_hit,
    input  logic                 dp_dirty,
    output logic                 dp_new_data,
    output logic                 dp_we,
    output logic                 dp_wdata_sel,
    output logic                 dp_wb,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOOKUP     = 3'd1,
        WB_SETUP   = 3'd2,
        WRITEBACK  = 3'd3,
        FILL_SETUP = 3'd4,
        FILL       = 3'd5,
        RESPOND    = 3'd6
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   refill_r;
    logic   refill_next_s;

    // State and refill flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            refill_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            refill_r <= refill_next_s;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_next_s  = state_r;
        refill_next_s = refill_r;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        dp_new_data   = 1'b0;
        dp_we         = 1'b0;
        dp_wdata_sel  = 1'b0;
        dp_wb         = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_next_s  = LOOKUP;
                    refill_next_s = 1'b0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOOKUP: begin
                if (dp_hit) begin
                    // mem_write wins when both request lines are high
                    if (mem_write) begin
                        dp_we        = 1'b1;
                        dp_new_data  = 1'b0;
                        dp_wdata_sel = 1'b1;
                    end else begin
                        dp_we = 1'b0;
                    end
                    state_next_s = RESPOND;
                end else if (dp_dirty) begin
                    state_next_s = WB_SETUP;
                end else begin
                    state_next_s = FILL_SETUP;
                end
            end
            WB_SETUP: begin
                dp_wb        = 1'b1;
                state_next_s = WRITEBACK;
            end
            WRITEBACK: begin
                dp_wb      = 1'b1;
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    state_next_s = FILL_SETUP;
                end else begin
                    state_next_s = WRITEBACK;
                end
            end
            FILL_SETUP: begin
                state_next_s = FILL;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    dp_we         = 1'b1;
                    dp_new_data   = 1'b1;
                    dp_wdata_sel  = 1'b0;
                    refill_next_s = 1'b1;
                    state_next_s  = LOOKUP;
                end else begin
                    state_next_s = FILL;
                end
            end
            RESPOND: begin
                mem_resp     = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

`ifdef L2_CACHE_PERF_COUNTERS_EN
    logic hit_inc_s;
    logic miss_inc_s;
    logic wb_inc_s;
    logic [CNT_WIDTH-1:0] hit_count_r;
    logic [CNT_WIDTH-1:0] miss_count_r;
    logic [CNT_WIDTH-1:0] wb_count_r;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value,
                                                     input logic inc);
        if (inc && (value != {CNT_WIDTH{1'b1}})) begin
            return value + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return value;
        end
    endfunction

    // Re-lookups after a fill are not counted as hits or misses
    assign hit_inc_s  = (state_r == LOOKUP) && dp_hit && !refill_r;
    assign miss_inc_s = (state_r == LOOKUP) && !dp_hit && !refill_r;
    assign wb_inc_s   = (state_r == LOOKUP) && !dp_hit && dp_dirty;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_r  <= {CNT_WIDTH{1'b0}};
            miss_count_r <= {CNT_WIDTH{1'b0}};
            wb_count_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            hit_count_r  <= sat_inc(hit_count_r, hit_inc_s);
            miss_count_r <= sat_inc(miss_count_r, miss_inc_s);
            wb_count_r   <= sat_inc(wb_count_r, wb_inc_s);
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
    assign wb_count   = wb_count_r;
`else
    assign hit_count  = {CNT_WIDTH{1'b0}};
    assign miss_count = {CNT_WIDTH{1'b0}};
    assign wb_count   = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed self-checking bench for l2_cache_control; counter expectations follow
// whether L2_CACHE_PERF_COUNTERS_EN is defined.
module tb_l2_cache_control;

    localparam int CW = 4;

`ifdef L2_CACHE_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_read = 1'b0;
    logic mem_write = 1'b0;
    logic pmem_resp = 1'b0;
    logic dp_hit = 1'b0;
    logic dp_dirty = 1'b0;
    logic mem_resp, pmem_read, pmem_write;
    logic dp_new_data, dp_we, dp_wdata_sel, dp_wb;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    int n_cmp = 0;
    int n_bad = 0;
    int resp_cyc, resp_n, rd_n, wr_n, wb_n, we_n, fill_n, hitwe_n, overlap_n;

    l2_cache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .dp_hit(dp_hit), .dp_dirty(dp_dirty),
        .dp_new_data(dp_new_data), .dp_we(dp_we), .dp_wdata_sel(dp_wdata_sel), .dp_wb(dp_wb),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ec(input int v);
        return PERF ? 32'(v) : 32'd0;
    endfunction

    function automatic logic [31:0] all_outs();
        return {13'd0, mem_resp, pmem_read, pmem_write, dp_new_data, dp_we, dp_wdata_sel,
                dp_wb, hit_count, miss_count, wb_count};
    endfunction

    // One transaction; cycle 0 is the first cycle the request is presented.
    // Memory answers in the w-th WRITEBACK / f-th FILL cycle; the line hits after a fill.
    task automatic run_txn(input bit wr, input bit hit0, input bit dirty, input int w, input int f);
        int wc = 0;
        int fc = 0;
        resp_cyc = -1; resp_n = 0; rd_n = 0; wr_n = 0; wb_n = 0;
        we_n = 0; fill_n = 0; hitwe_n = 0; overlap_n = 0;
        @(posedge clk); #1;
        mem_read = !wr; mem_write = wr; dp_hit = hit0; dp_dirty = dirty;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pmem_read && pmem_write) overlap_n++;
            if (pmem_write) begin
                wr_n++; wc++; pmem_resp = (wc == w);
            end else if (pmem_read) begin
                rd_n++; fc++; pmem_resp = (fc == f);
            end else begin
                pmem_resp = 1'b0;
            end
            #1;
            if (dp_wb) wb_n++;
            if (dp_we) begin
                we_n++;
                if (dp_new_data && !dp_wdata_sel && pmem_read && pmem_resp) fill_n++;
                else if (!dp_new_data && dp_wdata_sel && !pmem_read && !pmem_write) hitwe_n++;
            end
            if (mem_resp) begin
                resp_n++;
                if (resp_cyc < 0) resp_cyc = c;
            end
            if (pmem_read && pmem_resp) begin
                dp_hit = 1'b1; dp_dirty = 1'b0;
            end
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (resp_cyc >= 0) begin
                mem_read = 1'b0; mem_write = 1'b0;
                break;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        if (mem_resp) resp_n++;
    endtask

    initial begin
        // Reset state, then reset in the middle of a fill
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_read = 1'b1; dp_hit = 1'b0; dp_dirty = 1'b0;
        for (int i = 0; i < 10 && !pmem_read; i++) begin
            @(posedge clk); #1;
        end
        check_eq("reach_fill", 32'(pmem_read), 32'd1);
        check_eq("miss_before_rst", 32'(miss_count), ec(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_fill", all_outs(), 32'd0);
        mem_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_after_rst", all_outs(), 32'd0);

        // Read hit
        run_txn(1'b0, 1'b1, 1'b0, 1, 1);
        check_eq("rd_hit_resp_cyc", 32'(resp_cyc), 32'd2);
        check_eq("rd_hit_resp_pulses", 32'(resp_n), 32'd1);
        check_eq("rd_hit_pmem", 32'(rd_n + wr_n), 32'd0);
        check_eq("rd_hit_we", 32'(we_n), 32'd0);
        check_eq("rd_hit_hit_count", 32'(hit_count), ec(1));

        // Write hit
        run_txn(1'b1, 1'b1, 1'b0, 1, 1);
        check_eq("wr_hit_resp_cyc", 32'(resp_cyc), 32'd2);
        check_eq("wr_hit_we", 32'(we_n), 32'd1);
        check_eq("wr_hit_we_ctrl", 32'(hitwe_n), 32'd1);
        check_eq("wr_hit_hit_count", 32'(hit_count), ec(2));

        // Clean read miss, memory answers in the third FILL cycle
        run_txn(1'b0, 1'b0, 1'b0, 1, 3);
        check_eq("clean_rd_cycles", 32'(rd_n), 32'd3);
        check_eq("clean_wr_cycles", 32'(wr_n), 32'd0);
        check_eq("clean_fill_write", 32'(fill_n), 32'd1);
        check_eq("clean_we", 32'(we_n), 32'd1);
        check_eq("clean_resp_cyc", 32'(resp_cyc), 32'd7);
        check_eq("clean_resp_pulses", 32'(resp_n), 32'd1);
        check_eq("clean_miss_count", 32'(miss_count), ec(1));
        check_eq("clean_hit_count", 32'(hit_count), ec(2));

        // Dirty write miss, W=2 F=2: LOOKUP,WB_SETUP,WB x2,FILL_SETUP,FILL x2,LOOKUP,RESPOND
        run_txn(1'b1, 1'b0, 1'b1, 2, 2);
        check_eq("dirty_wb_cycles", 32'(wb_n), 32'd3);
        check_eq("dirty_wr_cycles", 32'(wr_n), 32'd2);
        check_eq("dirty_rd_cycles", 32'(rd_n), 32'd2);
        check_eq("dirty_overlap", 32'(overlap_n), 32'd0);
        check_eq("dirty_fill_write", 32'(fill_n), 32'd1);
        check_eq("dirty_hit_write", 32'(hitwe_n), 32'd1);
        check_eq("dirty_resp_cyc", 32'(resp_cyc), 32'd9);
        check_eq("dirty_wb_count", 32'(wb_count), ec(1));
        check_eq("dirty_miss_count", 32'(miss_count), ec(2));

        // Saturation of the 4-bit hit counter
        for (int k = 0; k < 17; k++) begin
            run_txn(1'b0, 1'b1, 1'b0, 1, 1);
        end
        check_eq("sat_resp_cyc", 32'(resp_cyc), 32'd2);
        check_eq("sat_hit_count", 32'(hit_count), ec(15));
        check_eq("sat_miss_count", 32'(miss_count), ec(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
